load_wb_unit: RTL and testbench

- Parametrised writeback stage for the MEM->WB boundary; successor to the purely combinational writeback path.
- Owns the data-RAM read handshake with variable latency and stalls the pipeline while a load is outstanding.
- Aligns and sign/zero-extends byte/half/word/dword loads for DATA_WIDTH 32 or 64; flags misaligned and timed-out loads.
- Drives a registered regfile write port and debug signals.

---
 rtl/load_wb_unit_pkg.sv | 35 +++
 rtl/load_wb_unit_align.sv | 60 ++++++
 rtl/load_wb_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_load_wb_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_wb_unit_pkg.sv
// Shared encodings for the load writeback stage: access sizes, FSM states, unaligned modes.
// Optional feature macro: UNALIGNED_LOAD_EN (LWL/LWR merge support).
package load_wb_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_e;

    typedef enum logic [1:0] {
        UA_NORMAL = 2'd0,
        UA_LWL    = 2'd1,
        UA_LWR    = 2'd2
    } ua_mode_e;

    // Size must be legal for the datapath and the address naturally aligned to it.
    function automatic logic access_ok(input logic [1:0] size, input logic [2:0] low, input int dw);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~low[0];
            SIZE_W:  ok = (low[1:0] == 2'b00);
            default: ok = (dw == 64) && (low == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_wb_unit_align.sv
// Purpose: pick the addressed lane out of a read word and sign/zero-extend it (optionally LWL/LWR merge).
// Latency: purely combinational. Backpressure: none, no handshake.
// Optional feature macro: UNALIGNED_LOAD_EN adds mode/old inputs for LWL/LWR.
module load_align
    import load_wb_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH/8)
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [OFF_W-1:0]      offset,
    input  logic [1:0]            size,
    input  logic                  sign,
`ifdef UNALIGNED_LOAD_EN
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] old,
`endif
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] shifted;
    int                    nbits;

`ifdef UNALIGNED_LOAD_EN
    logic [DATA_WIDTH-1:0] word_sh;
    logic [31:0]           word;
    logic [31:0]           merged;
    logic [63:0]           merged64;
    int                    o_i;
`endif

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        nbits   = 8 << size;
        if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
        result  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            result[i] = (i < nbits) ? shifted[i] : (sign & shifted[nbits-1]);
        end
`ifdef UNALIGNED_LOAD_EN
        // LWL/LWR work on the 32-bit word holding the address; bytes outside the access keep old data.
        word_sh  = rdata >> {offset[OFF_W-1:2], 5'b00000};
        word     = word_sh[31:0];
        o_i      = int'(offset[1:0]);
        merged   = '0;
        if (mode == UA_LWL) begin
            merged = (word << (8*(3-o_i))) | (old[31:0] & ((32'h1 << (8*(3-o_i))) - 32'h1));
        end else if (mode == UA_LWR) begin
            merged = (word >> (8*o_i)) | (old[31:0] & ~(32'hFFFF_FFFF >> (8*o_i)));
        end
        merged64 = {32'h0, merged};
        if (mode == UA_LWL || mode == UA_LWR) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                result[i] = (i < 32) ? merged64[i] : (sign & merged64[31]);
            end
        end
`endif
    end

endmodule

// File: rtl/load_wb_unit.sv
// Purpose: MEM->WB stage; runs the data-RAM read handshake, aligns/extends loads, drives the regfile port.
// Latency: 1 cycle for non-loads; loads retire the cycle after ram_rvalid (timeout after TIMEOUT_CYCLES).
// Backpressure: stall_out is held while a load is outstanding. Optional macro: UNALIGNED_LOAD_EN.
module load_wb_unit
    import load_wb_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      mem_sign_ext,
    input  logic [1:0]                mem_size,
    input  logic [DATA_WIDTH-1:0]     result_in,
    input  logic                      reg_write_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_in,
    input  logic [ADDR_WIDTH-1:0]     pc_in,
`ifdef UNALIGNED_LOAD_EN
    input  logic [1:0]                mem_unaligned_mode,
    input  logic [DATA_WIDTH-1:0]     reg_old_data,
`endif
    output logic                      ram_req,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    input  logic                      ram_rvalid,
    input  logic [DATA_WIDTH-1:0]     ram_rdata,
    output logic                      stall_out,
    output logic [DATA_WIDTH-1:0]     result_out,
    output logic                      reg_write_en_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_write_addr_out,
    output logic                      addr_error,
    output logic                      bus_error,
    output logic [ADDR_WIDTH-1:0]     debug_pc_out
);

    localparam int OFF_W = $clog2(DATA_WIDTH/8);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES+1) : 1;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    wb_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [1:0]                size_q, size_d;
    logic                      sign_q, sign_d;
    logic [OFF_W-1:0]          off_q, off_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;

    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic                      wen_q, wen_d;
    logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                      addr_err_q, addr_err_d;
    logic                      bus_err_q, bus_err_d;
    logic [ADDR_WIDTH-1:0]     dbg_pc_q, dbg_pc_d;

    logic [ADDR_WIDTH-1:0]     addr_in, aligned_in;
    logic                      ok_in;
    logic                      in_wait;
    logic [DATA_WIDTH-1:0]     align_out;

`ifdef UNALIGNED_LOAD_EN
    logic [1:0]                mode_q, mode_d;
    logic [DATA_WIDTH-1:0]     old_q, old_d;
`endif

    assign addr_in    = ADDR_WIDTH'(result_in);
    assign aligned_in = {addr_in[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign in_wait    = (state_q == ST_WAIT);
    assign cnt_inc    = cnt_q + CNT_W'(1);

    always_comb begin
        ok_in = access_ok(mem_size, addr_in[2:0], DATA_WIDTH);
`ifdef UNALIGNED_LOAD_EN
        if (mem_unaligned_mode != UA_NORMAL) ok_in = 1'b1;
`endif
    end

    // In IDLE the aligner sees the live request so a zero-latency response retires correctly.
    load_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (OFF_W)
    ) u_align (
        .rdata  (ram_rdata),
        .offset (in_wait ? off_q  : addr_in[OFF_W-1:0]),
        .size   (in_wait ? size_q : mem_size),
        .sign   (in_wait ? sign_q : mem_sign_ext),
`ifdef UNALIGNED_LOAD_EN
        .mode   (in_wait ? mode_q : mem_unaligned_mode),
        .old    (in_wait ? old_q  : reg_old_data),
`endif
        .result (align_out)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        sign_d     = sign_q;
        off_d      = off_q;
        dest_d     = dest_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
`ifdef UNALIGNED_LOAD_EN
        mode_d     = mode_q;
        old_d      = old_q;
`endif
        result_d   = result_q;
        wen_d      = 1'b0;
        waddr_d    = '0;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        dbg_pc_d   = '0;
        ram_req    = 1'b0;
        ram_addr   = '0;
        stall_out  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && mem_read) begin
                    waddr_d  = reg_write_addr_in;
                    dbg_pc_d = pc_in;
                    if (!ok_in) begin
                        result_d   = '0;
                        addr_err_d = 1'b1;
                    end else begin
                        ram_req  = 1'b1;
                        ram_addr = aligned_in;
                        size_d   = mem_size;
                        sign_d   = mem_sign_ext;
                        off_d    = addr_in[OFF_W-1:0];
                        dest_d   = reg_write_addr_in;
                        pc_d     = pc_in;
                        addr_d   = aligned_in;
                        cnt_d    = '0;
`ifdef UNALIGNED_LOAD_EN
                        mode_d   = mem_unaligned_mode;
                        old_d    = reg_old_data;
`endif
                        if (ram_rvalid) begin
                            result_d = align_out;
                            wen_d    = 1'b1;
                        end else begin
                            stall_out = 1'b1;
                            state_d   = ST_WAIT;
                        end
                    end
                end else if (in_valid) begin
                    result_d = mem_write ? '0 : result_in;
                    wen_d    = reg_write_en_in & ~mem_write;
                    waddr_d  = reg_write_addr_in;
                    dbg_pc_d = pc_in;
                end
            end
            default: begin
                ram_addr = addr_q;
                if (ram_rvalid) begin
                    result_d = align_out;
                    wen_d    = 1'b1;
                    waddr_d  = dest_q;
                    dbg_pc_d = pc_q;
                    state_d  = ST_IDLE;
                end else begin
                    ram_req   = 1'b1;
                    stall_out = 1'b1;
                    cnt_d     = cnt_inc;
                    if (TIMEOUT_CYCLES != 0 && cnt_inc == TMO) begin
                        bus_err_d = 1'b1;
                        waddr_d   = dest_q;
                        dbg_pc_d  = pc_q;
                        state_d   = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            off_q      <= '0;
            dest_q     <= '0;
            pc_q       <= '0;
            addr_q     <= '0;
`ifdef UNALIGNED_LOAD_EN
            mode_q     <= '0;
            old_q      <= '0;
`endif
            result_q   <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            dbg_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            off_q      <= off_d;
            dest_q     <= dest_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
`ifdef UNALIGNED_LOAD_EN
            mode_q     <= mode_d;
            old_q      <= old_d;
`endif
            result_q   <= result_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
            dbg_pc_q   <= dbg_pc_d;
        end
    end

    assign result_out         = result_q;
    assign reg_write_en_out   = wen_q;
    assign reg_write_addr_out = waddr_q;
    assign addr_error         = addr_err_q;
    assign bus_error          = bus_err_q;
    assign debug_pc_out       = dbg_pc_q;

endmodule

// File: tb/tb_load_wb_unit.sv
// Directed plus randomized checks of load_wb_unit (32-bit datapath, timeout of 4 wait cycles).
module tb_load_wb_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid, mem_read, mem_write, mem_sign_ext;
    logic [1:0]  mem_size;
    logic [31:0] result_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] pc_in;
`ifdef UNALIGNED_LOAD_EN
    logic [1:0]  mem_unaligned_mode;
    logic [31:0] reg_old_data;
`endif
    logic        ram_req;
    logic [31:0] ram_addr;
    logic        ram_rvalid;
    logic [31:0] ram_rdata;
    logic        stall_out;
    logic [31:0] result_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic        addr_error, bus_error;
    logic [31:0] debug_pc_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result;

    load_wb_unit #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_sign_ext       (mem_sign_ext),
        .mem_size           (mem_size),
        .result_in          (result_in),
        .reg_write_en_in    (reg_write_en_in),
        .reg_write_addr_in  (reg_write_addr_in),
        .pc_in              (pc_in),
`ifdef UNALIGNED_LOAD_EN
        .mem_unaligned_mode (mem_unaligned_mode),
        .reg_old_data       (reg_old_data),
`endif
        .ram_req            (ram_req),
        .ram_addr           (ram_addr),
        .ram_rvalid         (ram_rvalid),
        .ram_rdata          (ram_rdata),
        .stall_out          (stall_out),
        .result_out         (result_out),
        .reg_write_en_out   (reg_write_en_out),
        .reg_write_addr_out (reg_write_addr_out),
        .addr_error         (addr_error),
        .bus_error          (bus_error),
        .debug_pc_out       (debug_pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the addressed lane of the read word, extended by arithmetic on a 64-bit value.
    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input int size, input bit sgn);
        longint unsigned lane, mask;
        int nb;
        nb   = 1 << size;
        mask = (64'd1 << (8*nb)) - 64'd1;
        lane = ({32'd0, rdata} >> (8*(addr % 4))) & mask;
        if (sgn && lane[8*nb-1]) lane = lane | ~mask;
        return lane[31:0];
    endfunction

    function automatic bit load_ok(input logic [31:0] addr, input int size);
        return (size < 3) && ((addr % (1 << size)) == 0);
    endfunction

    task automatic do_alu(input logic [31:0] val, input bit wr, input bit wen,
                          input logic [4:0] dest, input logic [31:0] pc);
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b0; mem_write = wr; result_in = val;
        reg_write_en_in = wen; reg_write_addr_in = dest; pc_in = pc; ram_rvalid = 1'b0;
        #1;
        chk("alu_stall", 64'(stall_out), 64'd0);
        chk("alu_ram_req", 64'(ram_req), 64'd0);
        @(posedge clk); #1;
        last_result = wr ? 32'd0 : val;
        chk("alu_result", 64'(result_out), 64'(last_result));
        chk("alu_wen", 64'(reg_write_en_out), 64'(wen & ~wr));
        chk("alu_waddr", 64'(reg_write_addr_out), 64'(dest));
        chk("alu_pc", 64'(debug_pc_out), 64'(pc));
    endtask

    task automatic do_load(input logic [31:0] addr, input int size, input bit sgn,
                           input logic [4:0] dest, input logic [31:0] pc, input int lat,
                           input logic [31:0] rdata);
        bit ok;
        int stalls;
        ok = load_ok(addr, size);
        stalls = 0;
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_sign_ext = sgn;
        mem_size = 2'(size); result_in = addr; reg_write_en_in = 1'b1;
        reg_write_addr_in = dest; pc_in = pc; ram_rdata = rdata;
        ram_rvalid = ok && (lat == 0);
        #1;
        chk("ld_ram_req", 64'(ram_req), 64'(ok));
        chk("ld_ram_addr", 64'(ram_addr), ok ? 64'(addr & ~32'd3) : 64'd0);
        if (ok) begin
            if (stall_out) stalls++;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                ram_rvalid = (k == lat);
                #1;
                if (stall_out) stalls++;
                if (k == lat) chk("ld_req_drop", 64'(ram_req), 64'd0);
            end
            chk("ld_stall_cycles", 64'(stalls), 64'(lat));
        end else begin
            chk("ld_mis_stall", 64'(stall_out), 64'd0);
        end
        @(posedge clk); #1;
        last_result = ok ? exp_load(rdata, addr, size, sgn) : 32'd0;
        chk("ld_result", 64'(result_out), 64'(last_result));
        chk("ld_wen", 64'(reg_write_en_out), 64'(ok));
        chk("ld_addr_error", 64'(addr_error), 64'(!ok));
        if (ok) begin
            chk("ld_waddr", 64'(reg_write_addr_out), 64'(dest));
            chk("ld_pc", 64'(debug_pc_out), 64'(pc));
        end
        @(negedge clk);
        in_valid = 1'b0; mem_read = 1'b0; ram_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("idle_wen", 64'(reg_write_en_out), 64'd0);
        chk("idle_addr_error", 64'(addr_error), 64'd0);
        chk("idle_result_hold", 64'(result_out), 64'(last_result));
    endtask

    initial begin
        bit seen;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_sign_ext = 1'b0;
        mem_size = 2'd0; result_in = '0; reg_write_en_in = 1'b0; reg_write_addr_in = '0;
        pc_in = '0; ram_rvalid = 1'b0; ram_rdata = '0; last_result = '0;
`ifdef UNALIGNED_LOAD_EN
        mem_unaligned_mode = 2'd0; reg_old_data = '0;
`endif
        #12;
        chk("rst_result", 64'(result_out), 64'd0);
        chk("rst_wen", 64'(reg_write_en_out), 64'd0);
        chk("rst_waddr", 64'(reg_write_addr_out), 64'd0);
        chk("rst_errs", 64'({addr_error, bus_error}), 64'd0);
        chk("rst_pc", 64'(debug_pc_out), 64'd0);
        chk("rst_req_stall", 64'({ram_req, stall_out}), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        do_alu(32'h1234_5678, 1'b0, 1'b1, 5'd3, 32'h0000_0100);
        do_alu(32'hDEAD_BEEF, 1'b1, 1'b1, 5'd7, 32'h0000_0104);
        do_load(32'h0000_1003, 0, 1'b1, 5'd4, 32'h0000_0108, 3, 32'h80FF_0000);
        do_load(32'h0000_2002, 1, 1'b0, 5'd5, 32'h0000_010C, 2, 32'hBEEF_0000);
        do_load(32'h0000_3001, 2, 1'b0, 5'd6, 32'h0000_0110, 0, 32'h1111_2222);
        do_load(32'h0000_3000, 2, 1'b1, 5'd8, 32'h0000_0114, 0, 32'hCAFE_F00D);
        do_load(32'h0000_3004, 3, 1'b0, 5'd9, 32'h0000_0118, 1, 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) begin
                do_alu($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       5'($urandom), $urandom);
            end else begin
                do_load(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 5'($urandom),
                        $urandom, $urandom_range(0, 4), $urandom);
            end
        end

        // Timeout: no response ever arrives.
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b1; mem_size = 2'd2; result_in = 32'h0000_5000;
        reg_write_addr_in = 5'd10; pc_in = 32'h0000_0200; ram_rvalid = 1'b0;
        seen = 1'b0; n = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            n = k;
            seen = bus_error;
        end
        chk("tmo_cycles", 64'(n), 64'd5);
        chk("tmo_seen", 64'(seen), 64'd1);
        chk("tmo_wen", 64'(reg_write_en_out), 64'd0);
        @(negedge clk); in_valid = 1'b0; mem_read = 1'b0; #1;
        chk("tmo_stall_released", 64'({stall_out, ram_req}), 64'd0);
        @(posedge clk); #1;
        chk("tmo_pulse", 64'(bus_error), 64'd0);

        // Reset while a load is outstanding, then a late response.
        do_alu(32'h5555_AAAA, 1'b0, 1'b1, 5'd11, 32'h0000_0300);
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b1; mem_size = 2'd2; result_in = 32'h0000_6000;
        reg_write_addr_in = 5'd12; pc_in = 32'h0000_0304;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0;
        #1;
        chk("rstw_req_stall", 64'({ram_req, stall_out}), 64'd0);
        chk("rstw_result", 64'(result_out), 64'd0);
        chk("rstw_wen", 64'(reg_write_en_out), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); ram_rvalid = 1'b1; ram_rdata = 32'h7777_8888; #1;
        chk("late_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        chk("late_wen", 64'(reg_write_en_out), 64'd0);
        chk("late_result", 64'(result_out), 64'd0);
        @(negedge clk); ram_rvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
